// File: rtl/trigger_arbiter_pkg.sv
// Shared types and constants for trigger_arbiter and its round-robin picker.
package trigger_arbiter_pkg;

    localparam int unsigned DROP_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PULSE   = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

endpackage

// File: rtl/trigger_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of pending at or above ptr, wrapping.
module rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned PW = 2
) (
    input  logic [N-1:0]  pending,
    input  logic [PW-1:0] ptr,
    output logic          valid,
    output logic [PW-1:0] sel
);

    // Scan offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        int idx;
        valid = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= int'(N)) begin
                idx = idx - int'(N);
            end
            if (pending[PW'(idx)]) begin
                valid = 1'b1;
                sel   = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/trigger_arbiter.sv
// Round-robin arbiter sharing one programmable one-shot pulse stage among NUM_REQ requesters.
// Optional requester drop counter enabled by defining TRIGGER_ARBITER_DROP_COUNT_EN.
module trigger_arbiter
    import trigger_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned CW      = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               enable,
    input  logic [CW-1:0]      pulse_width,
    input  logic [CW-1:0]      holdoff,
`ifdef TRIGGER_ARBITER_DROP_COUNT_EN
    input  logic               drop_clear,
    output logic [DROP_W-1:0]  drop_count,
`endif
    output logic               q,
    output logic [NUM_REQ-1:0] grant,
    output logic [NUM_REQ-1:0] ack,
    output logic [NUM_REQ-1:0] pending,
    output logic               busy
);

    localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t             state;
    logic [PW-1:0]      ptr;
    logic [PW-1:0]      sel;
    logic               pick_valid;
    logic [CW-1:0]      cnt;
    logic [CW-1:0]      hold_lat;
    logic               start_c;
    logic [NUM_REQ-1:0] gnt_now_c;

    rr_pick #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_pick (
        .pending (pending),
        .ptr     (ptr),
        .valid   (pick_valid),
        .sel     (sel)
    );

    assign start_c   = (state == IDLE) && enable && pick_valid;
    assign gnt_now_c = start_c ? (NUM_REQ'(1) << sel) : '0;

    // A request on the grant edge survives the clear and becomes a fresh pending entry.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~gnt_now_c) | req;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            ptr      <= '0;
            cnt      <= '0;
            hold_lat <= '0;
            q        <= 1'b0;
            grant    <= '0;
            ack      <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ack <= '0;
                    if (start_c) begin
                        state    <= PULSE;
                        grant    <= gnt_now_c;
                        ack      <= gnt_now_c;
                        q        <= 1'b1;
                        busy     <= 1'b1;
                        cnt      <= (pulse_width == '0) ? '0 : pulse_width - CW'(1);
                        hold_lat <= holdoff;
                        ptr      <= (sel == PW'(NUM_REQ - 1)) ? '0 : sel + PW'(1);
                    end
                end
                PULSE: begin
                    ack <= '0;
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        q <= 1'b0;
                        if (hold_lat == '0) begin
                            state <= IDLE;
                            grant <= '0;
                            busy  <= 1'b0;
                        end else begin
                            state <= HOLDOFF;
                            cnt   <= hold_lat - CW'(1);
                        end
                    end
                end
                HOLDOFF: begin
                    ack <= '0;
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        state <= IDLE;
                        grant <= '0;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    q     <= 1'b0;
                    grant <= '0;
                    ack   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef TRIGGER_ARBITER_DROP_COUNT_EN
    localparam int unsigned IW = $clog2(NUM_REQ + 1);
    localparam int unsigned SW = DROP_W + 1;

    logic [NUM_REQ-1:0] drop_hits_c;
    logic [IW-1:0]      drop_inc_c;
    logic [SW-1:0]      drop_sum_c;

    // Merged requests: already pending and not being served this edge.
    always_comb begin
        drop_hits_c = req & pending & ~gnt_now_c;
        drop_inc_c  = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            drop_inc_c = drop_inc_c + IW'(drop_hits_c[i]);
        end
        drop_sum_c = {1'b0, drop_count} + SW'(drop_inc_c);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            drop_count <= '0;
        end else if (drop_clear) begin
            drop_count <= '0;
        end else if (drop_sum_c[DROP_W]) begin
            drop_count <= '1;
        end else begin
            drop_count <= drop_sum_c[DROP_W-1:0];
        end
    end
`endif

endmodule

// File: tb/tb_trigger_arbiter.sv
// Scoreboard bench for trigger_arbiter: directed scenarios followed by random traffic.
module tb_trigger_arbiter;

    localparam int NREQ = 4;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic [NREQ-1:0] req = '0;
    logic            enable = 1'b0;
    logic [7:0]      pulse_width = 8'd1;
    logic [7:0]      holdoff = 8'd0;
    logic            q;
    logic [NREQ-1:0] grant;
    logic [NREQ-1:0] ack;
    logic [NREQ-1:0] pending;
    logic            busy;
`ifdef TRIGGER_ARBITER_DROP_COUNT_EN
    logic            drop_clear = 1'b0;
    logic [15:0]     drop_count;
`endif

    trigger_arbiter #(.NUM_REQ(NREQ), .CW(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .req         (req),
        .enable      (enable),
        .pulse_width (pulse_width),
        .holdoff     (holdoff),
`ifdef TRIGGER_ARBITER_DROP_COUNT_EN
        .drop_clear  (drop_clear),
        .drop_count  (drop_count),
`endif
        .q           (q),
        .grant       (grant),
        .ack         (ack),
        .pending     (pending),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        int idx;
        int edge_n;
    } exp_t;

    exp_t sbq[$];

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: service timeline expressed in absolute edge numbers.
    int            edge_no = 0;
    logic [NREQ-1:0] m_pend = '0;
    int            m_ptr = 0;
    int            next_free = 0;
    int            busy_until = -1;
    int            q_until = -1;
    int            cur_idx = 0;
    int            m_drop = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at edge %0d", name, act, exp, edge_no);
        end
    endtask

    always @(posedge clock) begin
        logic [NREQ-1:0] gnt;
        int gidx;
        int w;
        edge_no++;
        if (!reset) begin
            m_pend     = '0;
            m_ptr      = 0;
            next_free  = 0;
            busy_until = -1;
            q_until    = -1;
            cur_idx    = 0;
            m_drop     = 0;
            sbq.delete();
        end else begin
            gnt  = '0;
            gidx = -1;
            if (edge_no >= next_free && enable && m_pend != '0) begin
                for (int k = 0; k < NREQ; k++) begin
                    int idx;
                    idx = (m_ptr + k) % NREQ;
                    if (gidx < 0 && m_pend[idx[1:0]]) gidx = idx;
                end
                gnt        = NREQ'(1) << gidx;
                w          = (pulse_width == 8'd0) ? 1 : int'(pulse_width);
                next_free  = edge_no + w + int'(holdoff) + 1;
                busy_until = edge_no + w + int'(holdoff) - 1;
                q_until    = edge_no + w - 1;
                cur_idx    = gidx;
                m_ptr      = (gidx + 1) % NREQ;
                sbq.push_back('{gidx, edge_no});
            end
`ifdef TRIGGER_ARBITER_DROP_COUNT_EN
            if (drop_clear) begin
                m_drop = 0;
            end else begin
                for (int i = 0; i < NREQ; i++) begin
                    if (req[i] && m_pend[i] && !gnt[i] && m_drop < 65535) m_drop++;
                end
            end
`endif
            m_pend = (m_pend & ~gnt) | req;
        end
    end

    // Monitor: lockstep level checks plus ack-driven scoreboard pops.
    always @(negedge clock) begin
        if (reset) begin
            check("pending", 32'(pending), 32'(m_pend));
            check("q", 32'(q), 32'(edge_no <= q_until));
            check("busy", 32'(busy), 32'(edge_no <= busy_until));
            check("grant", 32'(grant), (edge_no <= busy_until) ? 32'(1) << cur_idx : 32'd0);
`ifdef TRIGGER_ARBITER_DROP_COUNT_EN
            check("drop_count", 32'(drop_count), 32'(m_drop));
`endif
            if (ack != '0) begin
                if (sbq.size() == 0) begin
                    check("ack_unexpected", 32'(ack), 32'd0);
                end else begin
                    exp_t r;
                    r = sbq.pop_front();
                    check("ack_owner", 32'(ack), 32'(1) << r.idx);
                    check("ack_edge", 32'(edge_no), 32'(r.edge_n));
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic pulse_req(input logic [NREQ-1:0] r, input int n);
        @(negedge clock);
        req = r;
        cyc(n);
        req = '0;
    endtask

    initial begin
        int waited;
        #1;
        check("rst_q", 32'(q), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        cyc(2);
        reset  = 1'b1;
        enable = 1'b1;

        // Single requester, width 3, holdoff 2.
        pulse_width = 8'd3;
        holdoff     = 8'd2;
        pulse_req(4'b0100, 1);
        cyc(10);

        // All requesters at once, served 0..3 and wrapping.
        pulse_width = 8'd1;
        holdoff     = 8'd0;
        pulse_req(4'b1111, 1);
        cyc(12);
        pulse_req(4'b0001, 1);
        cyc(4);

        // Zero width behaves as one cycle.
        pulse_width = 8'd0;
        pulse_req(4'b1000, 1);
        cyc(5);

        // Disabled arbiter holds the request.
        enable = 1'b0;
        pulse_req(4'b0010, 1);
        cyc(10);
        check("held_pending", 32'(pending), 32'b0010);
        enable = 1'b1;
        cyc(6);

        // Re-request on own grant edge, then three merged requests.
        pulse_width = 8'd5;
        holdoff     = 8'd2;
        pulse_req(4'b0001, 5);
`ifdef TRIGGER_ARBITER_DROP_COUNT_EN
        @(negedge clock);
        check("drop_three", 32'(drop_count), 32'd3);
`endif
        cyc(20);

        // Asynchronous reset in the middle of a long pulse.
        pulse_width = 8'd10;
        holdoff     = 8'd0;
        pulse_req(4'b0100, 1);
        cyc(3);
        #3 reset = 1'b0;
        #1;
        check("async_q", 32'(q), 32'd0);
        check("async_grant", 32'(grant), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        check("async_pending", 32'(pending), 32'd0);
        cyc(2);
        reset       = 1'b1;
        pulse_width = 8'd1;
        pulse_req(4'b1010, 1);
        cyc(8);

        // Random traffic with parameter churn mid-pulse.
        for (int i = 0; i < 2000; i++) begin
            @(negedge clock);
            req    = ($urandom_range(0, 4) == 0) ? NREQ'($urandom) : '0;
            enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 7) == 0) pulse_width = 8'($urandom_range(0, 4));
            if ($urandom_range(0, 7) == 0) holdoff = 8'($urandom_range(0, 3));
`ifdef TRIGGER_ARBITER_DROP_COUNT_EN
            drop_clear = ($urandom_range(0, 49) == 0);
`endif
        end

        @(negedge clock);
        req    = '0;
        enable = 1'b1;
`ifdef TRIGGER_ARBITER_DROP_COUNT_EN
        drop_clear = 1'b0;
`endif
        waited = 0;
        while (waited < 500 && !(edge_no > busy_until && m_pend == '0)) begin
            @(negedge clock);
            waited++;
        end
        check("drain_timeout", 32'(waited < 500), 32'd1);
        cyc(2);
        check("sb_empty", 32'(sbq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
